// File: rtl/fc_seq_control_if.sv
// Handshake and control bundle between fc_seq_control and the fc MAC datapath.
// master = sequencing controller, slave = datapath / stream endpoints.
interface fc_seq_control_if #(
    parameter int M = 6,
    parameter int N = 6,
    parameter int P = 1
);
    localparam int XW = (N > 1) ? $clog2(N) : 1;
    localparam int WW = ((M / P) * N > 1) ? $clog2((M / P) * N) : 1;
    localparam int SW = (P > 1) ? $clog2(P) : 1;

    logic          input_valid;
    logic          input_ready;
    logic          output_ready;
    logic          output_valid;
    logic          wr_en_x;
    logic [XW-1:0] addr_x;
    logic [WW-1:0] addr_w;
    logic          clear_acc;
    logic          valid_en_acc;
    logic [SW-1:0] sel;
    logic          layer_done;

    modport master (
        input  input_valid, output_ready,
        output input_ready, output_valid, wr_en_x, addr_x, addr_w,
               clear_acc, valid_en_acc, sel, layer_done
    );

    modport slave (
        output input_valid, output_ready,
        input  input_ready, output_valid, wr_en_x, addr_x, addr_w,
               clear_acc, valid_en_acc, sel, layer_done
    );
endinterface

// File: rtl/fc_seq_control.sv
// Sequencing controller for the shared fully-connected MAC datapath: loads x, then per
// row group issues N MAC cycles, drains the pipeline and streams the P lane results.
module fc_seq_control #(
    parameter int M    = 6,
    parameter int N    = 6,
    parameter int P    = 1,
    parameter int PIPE = 2
) (
    input logic              clk,
    input logic              reset,
    fc_seq_control_if.master bus
);
    localparam int G  = M / P;
    localparam int XW = (N > 1) ? $clog2(N) : 1;
    localparam int WW = (G * N > 1) ? $clog2(G * N) : 1;
    localparam int SW = (P > 1) ? $clog2(P) : 1;
    localparam int GW = (G > 1) ? $clog2(G) : 1;
    localparam int DW = (PIPE > 1) ? $clog2(PIPE) : 1;

    localparam logic [XW-1:0] X_LAST = XW'(N - 1);
    localparam logic [GW-1:0] G_LAST = GW'(G - 1);
    localparam logic [SW-1:0] L_LAST = SW'(P - 1);
    localparam logic [DW-1:0] D_LAST = DW'(PIPE - 1);

    typedef enum logic [2:0] {
        S_INIT,
        S_LOAD,
        S_MAC,
        S_DRAIN,
        S_OUT,
        S_CLR
    } state_t;

    state_t        state;
    state_t        state_n;
    logic [XW-1:0] xcnt;
    logic [XW-1:0] kcnt;
    logic [GW-1:0] gcnt;
    logic [WW-1:0] wcnt;
    logic [SW-1:0] lane;
    logic [DW-1:0] dcnt;
    logic          in_hs;
    logic          out_hs;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= S_INIT;
            xcnt  <= '0;
            kcnt  <= '0;
            gcnt  <= '0;
            wcnt  <= '0;
            lane  <= '0;
            dcnt  <= '0;
        end else begin
            state <= state_n;
            if (in_hs) begin
                xcnt <= (xcnt == X_LAST) ? '0 : xcnt + 1'b1;
            end
            // wcnt tracks g*N+k directly so no multiplier is needed for addr_w
            if (state == S_MAC) begin
                kcnt <= (kcnt == X_LAST) ? '0 : kcnt + 1'b1;
                wcnt <= (kcnt == X_LAST && gcnt == G_LAST) ? '0 : wcnt + 1'b1;
            end
            if (state == S_DRAIN) begin
                dcnt <= (dcnt == D_LAST) ? '0 : dcnt + 1'b1;
            end
            if (out_hs) begin
                lane <= (lane == L_LAST) ? '0 : lane + 1'b1;
            end
            if (state == S_CLR) begin
                gcnt <= (gcnt == G_LAST) ? '0 : gcnt + 1'b1;
            end
        end
    end

    always_comb begin
        state_n          = state;
        in_hs            = 1'b0;
        out_hs           = 1'b0;
        bus.input_ready  = 1'b0;
        bus.wr_en_x      = 1'b0;
        bus.addr_x       = '0;
        bus.addr_w       = '0;
        bus.clear_acc    = 1'b0;
        bus.valid_en_acc = 1'b0;
        bus.output_valid = 1'b0;
        bus.sel          = '0;
        bus.layer_done   = 1'b0;

        unique case (state)
            S_INIT: begin
                bus.clear_acc = 1'b1;
                state_n       = S_LOAD;
            end
            S_LOAD: begin
                bus.input_ready = 1'b1;
                bus.wr_en_x     = bus.input_valid;
                bus.addr_x      = xcnt;
                in_hs           = bus.input_valid;
                if (in_hs && xcnt == X_LAST) begin
                    state_n = S_MAC;
                end
            end
            S_MAC: begin
                bus.addr_x       = kcnt;
                bus.addr_w       = wcnt;
                bus.valid_en_acc = 1'b1;
                if (kcnt == X_LAST) begin
                    state_n = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (dcnt == D_LAST) begin
                    state_n = S_OUT;
                end
            end
            S_OUT: begin
                bus.output_valid = 1'b1;
                bus.sel          = lane;
                out_hs           = bus.output_ready;
                // layer_done marks the accepting cycle of the very last result
                if (out_hs && lane == L_LAST) begin
                    state_n        = S_CLR;
                    bus.layer_done = (gcnt == G_LAST);
                end
            end
            S_CLR: begin
                bus.clear_acc = 1'b1;
                state_n       = (gcnt == G_LAST) ? S_LOAD : S_MAC;
            end
            default: begin
                state_n = S_INIT;
            end
        endcase
    end
endmodule

// File: tb/tb_fc_seq_control.sv
// Directed bench for fc_seq_control: cycle tables plus hand sequences, with a small
// behavioural MAC datapath whose results are compared against relu(W*x).
module tb_fc_seq_control;
    localparam int M0 = 6, N0 = 6, P0 = 1, PIPE0 = 2;
    localparam int M1 = 6, N1 = 4, P1 = 2, PIPE1 = 2;

    logic clk = 1'b0;
    logic reset0;
    logic reset1;
    always #5 clk = ~clk;

    fc_seq_control_if #(.M(M0), .N(N0), .P(P0)) bus0 ();
    fc_seq_control_if #(.M(M1), .N(N1), .P(P1)) bus1 ();

    fc_seq_control #(.M(M0), .N(N0), .P(P0), .PIPE(PIPE0)) dut0 (
        .clk   (clk),
        .reset (reset0),
        .bus   (bus0)
    );

    fc_seq_control #(.M(M1), .N(N1), .P(P1), .PIPE(PIPE1)) dut1 (
        .clk   (clk),
        .reset (reset1),
        .bus   (bus1)
    );

    int total = 0;
    int bad   = 0;

    task automatic chk(input string nm, input int got, input int want);
        total++;
        if (got != want) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", nm, got, want);
        end
    endtask

    // behavioural datapath for dut0: x memory, weight ROM, 2-stage MAC, relu
    int   xmem [8];
    int   din0;
    int   prod;
    int   acc;
    logic p1v;
    int   x_cur [N0];
    int   out_idx;

    function automatic int w_of(input int a);
        int r;
        int c;
        r = a / N0;
        c = a % N0;
        return ((r * 5 + c * 3) % 9) - 4;
    endfunction

    function automatic int golden(input int r);
        int s;
        s = 0;
        for (int c = 0; c < N0; c++) s += w_of(r * N0 + c) * x_cur[c];
        return (s < 0) ? 0 : s;
    endfunction

    always @(posedge clk or posedge reset0) begin
        if (reset0) begin
            p1v <= 1'b0;
            acc <= 0;
        end else begin
            if (bus0.wr_en_x) xmem[bus0.addr_x] <= din0;
            p1v  <= bus0.valid_en_acc;
            prod <= xmem[bus0.addr_x] * w_of(int'(bus0.addr_w));
            if (bus0.clear_acc) acc <= 0;
            else if (p1v) acc <= acc + prod;
        end
    end

    function automatic int pk(input logic ir, input logic we, input logic [2:0] ax,
                              input logic [5:0] aw, input logic ve, input logic ca,
                              input logic ov, input logic sl, input logic ld);
        return int'({ir, we, ax, aw, ve, ca, ov, sl, ld});
    endfunction

    function automatic int obs0();
        return pk(bus0.input_ready, bus0.wr_en_x, bus0.addr_x, bus0.addr_w,
                  bus0.valid_en_acc, bus0.clear_acc, bus0.output_valid, bus0.sel,
                  bus0.layer_done);
    endfunction

    task automatic drive0(input logic iv, input int d, input logic ordy);
        bus0.input_valid  = iv;
        din0              = d;
        bus0.output_ready = ordy;
        #1;
        if (bus0.output_valid && bus0.output_ready) begin
            chk($sformatf("data%0d", out_idx), (acc < 0) ? 0 : acc, golden(out_idx));
            out_idx = (out_idx + 1) % (M0 / P0);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    typedef struct {
        logic iv;
        int   din;
        logic ordy;
        int   exp;
    } vec_t;
    vec_t tbl[$];

    task automatic add(input logic iv, input int d, input logic ordy, input int e);
        vec_t v;
        v.iv   = iv;
        v.din  = d;
        v.ordy = ordy;
        v.exp  = e;
        tbl.push_back(v);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int outs;
        int lds;
        int nld;
        int wexp;
        int hs;

        reset0 = 1'b1;
        reset1 = 1'b1;
        bus0.input_valid  = 1'b0;
        bus0.output_ready = 1'b0;
        bus1.input_valid  = 1'b0;
        bus1.output_ready = 1'b0;
        din0    = 0;
        out_idx = 0;

        // table: INIT, load 1..6 with a gap, full layer with output_ready high
        add(1'b1, 55, 1'b1, pk(0, 0, 0, 0, 0, 1, 0, 0, 0));
        for (int i = 0; i < N0; i++) begin
            add(1'b1, i + 1, 1'b1, pk(1, 1, 3'(i), 0, 0, 0, 0, 0, 0));
            if (i == 2) add(1'b0, 77, 1'b1, pk(1, 0, 3'(3), 0, 0, 0, 0, 0, 0));
        end
        for (int g = 0; g < M0; g++) begin
            for (int k = 0; k < N0; k++)
                add(1'b1, 99, 1'b1, pk(0, 0, 3'(k), 6'(g * N0 + k), 1, 0, 0, 0, 0));
            for (int d = 0; d < PIPE0; d++)
                add(1'b1, 99, 1'b1, pk(0, 0, 0, 0, 0, 0, 0, 0, 0));
            add(1'b1, 99, 1'b1, pk(0, 0, 0, 0, 0, 0, 1, 0, (g == M0 - 1)));
            add(1'b1, 99, 1'b1, pk(0, 0, 0, 0, 0, 1, 0, 0, 0));
        end
        add(1'b0, 0, 1'b1, pk(1, 0, 0, 0, 0, 0, 0, 0, 0));
        for (int i = 0; i < N0; i++) x_cur[i] = i + 1;

        tick();
        tick();
        drive0(1'b1, 0, 1'b1);
        chk("rst0_outputs", obs0(), pk(0, 0, 0, 0, 0, 1, 0, 0, 0));
        chk("rst1_clear", int'(bus1.clear_acc), 1);
        chk("rst1_ready", int'(bus1.input_ready), 0);
        reset0 = 1'b0;

        for (int i = 0; i < tbl.size(); i++) begin
            drive0(tbl[i].iv, tbl[i].din, tbl[i].ordy);
            chk($sformatf("vec%0d", i), obs0(), tbl[i].exp);
            tick();
        end

        // input_valid gaps: one element every 3 cycles
        x_cur = '{3, -2, 5, 0, 7, -4};
        for (int i = 0; i < N0; i++) begin
            for (int j = 0; j < 2; j++) begin
                drive0(1'b0, 0, 1'b0);
                chk("gap_hold", obs0(), pk(1, 0, 3'(i), 0, 0, 0, 0, 0, 0));
                tick();
            end
            drive0(1'b1, x_cur[i], 1'b0);
            chk("gap_accept", obs0(), pk(1, 1, 3'(i), 0, 0, 0, 0, 0, 0));
            tick();
        end
        drive0(1'b1, 0, 1'b0);
        chk("mac_start", obs0(), pk(0, 0, 0, 0, 1, 0, 0, 0, 0));
        n = 1;
        while (!bus0.output_valid && n < 40) begin
            tick();
            drive0(1'b0, 0, 1'b0);
            n++;
        end
        chk("first_out_latency", n, N0 + PIPE0 + 1);
        tick();

        // throttled output_ready: low for 3 cycles per element
        for (int j = 0; j < M0; j++) begin
            for (int h = 0; h < 3; h++) begin
                drive0(1'b0, 0, 1'b0);
                chk("thr_hold", obs0(), pk(0, 0, 0, 0, 0, 0, 1, 0, 0));
                tick();
            end
            drive0(1'b0, 0, 1'b1);
            chk("thr_accept", obs0(), pk(0, 0, 0, 0, 0, 0, 1, 0, (j == M0 - 1)));
            tick();
            drive0(1'b0, 0, 1'b0);
            chk("thr_clr", obs0(), pk(0, 0, 0, 0, 0, 1, 0, 0, 0));
            tick();
            if (j < M0 - 1) begin
                n = 1;
                drive0(1'b0, 0, 1'b0);
                while (!bus0.output_valid && n < 40) begin
                    tick();
                    drive0(1'b0, 0, 1'b0);
                    n++;
                end
                chk("thr_group_gap", n, N0 + PIPE0 + 1);
                tick();
            end
        end
        drive0(1'b0, 0, 1'b0);
        chk("reload", obs0(), pk(1, 0, 0, 0, 0, 0, 0, 0, 0));
        tick();

        // reset in the middle of MAC of the second group
        x_cur = '{2, 2, 2, 2, 2, 2};
        for (int i = 0; i < N0; i++) begin
            drive0(1'b1, x_cur[i], 1'b1);
            tick();
        end
        n = 0;
        drive0(1'b0, 0, 1'b1);
        while (!(bus0.valid_en_acc && bus0.addr_w == 6'd8) && n < 60) begin
            tick();
            drive0(1'b0, 0, 1'b1);
            n++;
        end
        chk("reach_group2", int'(n < 60), 1);
        #2;
        reset0 = 1'b1;
        #1;
        chk("async_reset", obs0(), pk(0, 0, 0, 0, 0, 1, 0, 0, 0));
        out_idx = 0;
        tick();
        drive0(1'b1, 0, 1'b1);
        chk("reset_hold", obs0(), pk(0, 0, 0, 0, 0, 1, 0, 0, 0));
        reset0 = 1'b0;
        drive0(1'b1, 0, 1'b1);
        chk("post_init", obs0(), pk(0, 0, 0, 0, 0, 1, 0, 0, 0));
        tick();
        x_cur = '{1, -1, 2, -2, 3, -3};
        for (int i = 0; i < N0; i++) begin
            drive0(1'b1, x_cur[i], 1'b1);
            chk("v4_load", obs0(), pk(1, 1, 3'(i), 0, 0, 0, 0, 0, 0));
            tick();
        end
        n = 0;
        outs = 0;
        lds = 0;
        nld = -1;
        while (n < 100 && lds == 0) begin
            drive0(1'b0, 0, 1'b1);
            if (bus0.output_valid) outs++;
            if (bus0.layer_done) begin
                lds++;
                nld = n;
                chk("v4_done_with_last", outs, M0);
            end
            tick();
            n++;
        end
        chk("v4_outputs", outs, M0);
        chk("v4_layer_done", lds, 1);
        chk("v4_done_cycle", nld, (M0 - 1) * (N0 + PIPE0 + P0 + 1) + N0 + PIPE0);

        // P=2, N=4 configuration
        reset1 = 1'b0;
        n = 0;
        wexp = 0;
        hs = 0;
        lds = 0;
        while (n < 80 && lds == 0) begin
            bus1.input_valid  = 1'b1;
            bus1.output_ready = 1'b1;
            #1;
            if (n == 0) chk("p2_init_clear", int'(bus1.clear_acc), 1);
            if (bus1.valid_en_acc) begin
                chk("p2_addr_w", int'(bus1.addr_w), wexp);
                wexp++;
            end
            if (bus1.output_valid) begin
                chk("p2_sel", int'(bus1.sel), hs % 2);
                hs++;
                if (bus1.layer_done) begin
                    lds++;
                    chk("p2_done_cycle", n, N1 + (M1 / P1) * (N1 + PIPE1 + P1 + 1) - 1);
                    chk("p2_done_handshakes", hs, M1);
                end
            end else begin
                chk("p2_no_done", int'(bus1.layer_done), 0);
            end
            tick();
            n++;
        end
        chk("p2_issue_count", wexp, (M1 / P1) * N1);
        chk("p2_handshakes", hs, M1);
        chk("p2_layer_done", lds, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
